// File: rtl/adder_top.sv
// adder_top: registered 32-bit adder built from eight 4-bit CLA blocks under a second-level lookahead unit
module adder_top (
  output logic        cout,
  output logic [31:0] sum,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cin,
  input  logic        clk,
  input  logic        rst
);
  // Carry into position n as a flat sum of products, so each level is one lookahead stage.
  function automatic logic la(input logic [7:0] g, input logic [7:0] p, input logic c0, input int n);
    logic r, t;
    r = 1'b0;
    for (int k = 0; k < n; k++) begin
      t = g[k];
      for (int m = k + 1; m < n; m++) t = t & p[m];
      r = r | t;
    end
    t = c0;
    for (int m = 0; m < n; m++) t = t & p[m];
    return r | t;
  endfunction
  logic [31:0] g, p, s;
  logic [7:0]  gg, gp;
  logic [8:0]  bc;
  assign g = A & B;
  assign p = A ^ B;
  for (genvar b = 0; b < 8; b++) begin : blk
    logic [3:0] c;
    assign gg[b] = la({4'b0, g[4*b +: 4]}, {4'b0, p[4*b +: 4]}, 1'b0, 4);
    assign gp[b] = &p[4*b +: 4];
    for (genvar i = 0; i < 4; i++) begin : bit_g
      assign c[i] = la({4'b0, g[4*b +: 4]}, {4'b0, p[4*b +: 4]}, bc[b], i);
      assign s[4*b+i] = p[4*b+i] ^ c[i];
    end
  end
  for (genvar j = 0; j < 9; j++) begin : top_la
    assign bc[j] = la(gg, gp, cin, j);
  end
  always_ff @(posedge clk)
    if (rst) {cout, sum} <= '0;
    else {cout, sum} <= {bc[8], s};
endmodule

// File: tb/tb_adder_top.sv
// tb_adder_top: randomized scoreboard bench for adder_top against an arithmetic reference
module tb_adder_top;
  logic        clk = 1'b0;
  logic        rst, cin, cout;
  logic [31:0] A, B, sum;
  typedef struct {
    logic [32:0] v;
    string       n;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  adder_top dut (.cout(cout), .sum(sum), .A(A), .B(B), .cin(cin), .clk(clk), .rst(rst));
  always #5 clk = ~clk;
  // Inputs change on the falling edge; the expected result is queued for the next rising edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic r, input string n);
    exp_t e;
    @(negedge clk);
    A = a; B = b; cin = c; rst = r;
    e.v = r ? 33'd0 : {1'b0, a} + {1'b0, b} + {32'd0, c};
    e.n = n;
    sb.push_back(e);
  endtask
  // Checks half a cycle later, after the inputs have already moved on to the next operand set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge clk);
        #1;
        checks++;
        if ({cout, sum} !== e.v) begin
          failures++;
          $display("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h", e.n, cout, sum, e.v[32], e.v[31:0]);
        end
      end
    end
  end
  initial begin
    A = '0; B = '0; cin = 1'b0; rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b1, "reset_state");
    drive(32'h00000000, 32'h11111111, 1'b0, 1'b0, "zero_plus");
    drive(32'h10101010, 32'h10101100, 1'b0, 1'b0, "pattern");
    drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "wrap");
    drive(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, "wrap_cin");
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, "all_ones");
    drive(32'h0000000F, 32'h00000001, 1'b0, 1'b0, "block_cross");
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "msb_carry");
    drive(32'h12345678, 32'h11111111, 1'b0, 1'b1, "reset_priority");
    drive(32'h12345678, 32'h11111111, 1'b0, 1'b0, "after_reset");
    drive(32'h00000000, 32'h00000000, 1'b1, 1'b0, "cin_only");
    drive(32'h80000000, 32'h80000000, 1'b0, 1'b0, "msb_overflow");
    for (int i = 0; i < 10000; i++)
      drive($urandom, $urandom, 1'($urandom), ($urandom_range(63) == 0), "random");
    drive(32'h0, 32'h0, 1'b0, 1'b0, "drain");
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_top.md
ADDER_TOP -- requirements
Module: adder_top

Interface
REQ-001 The module SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cout  output  1  registered carry-out of the 32-bit addition.
REQ-005 sum  output  32  registered 32-bit sum.
REQ-006 A  input  32  addend A, unsigned.
REQ-007 B  input  32  addend B, unsigned.
REQ-008 cin  input  1  carry-in.
REQ-009 Positional port order SHALL be: cout, sum, A, B, cin, clk, rst.

Function
REQ-010 On each rising clk edge with rst low, the register {cout,sum} SHALL load the 33-bit value A + B + cin.
REQ-011 Latency SHALL be exactly one clock: the outputs reflect the inputs sampled at the most recent rising edge.
REQ-012 The outputs SHALL be driven only from the register, with no combinational path from A, B or cin to cout or sum.
REQ-013 The adder SHALL be a carry-lookahead structure.
REQ-014 The structure SHALL use eight 4-bit CLA blocks, each computing bit generate g=a&b, propagate p=a^b, its internal carries, and group G/P.
REQ-015 A second-level lookahead unit SHALL combine group G/P into block carry-ins; a ripple chain across all 32 bits is not allowed.
REQ-016 Each sum bit SHALL be p[i] ^ c[i], and cout SHALL be the carry out of bit 31.
REQ-017 There SHALL be no handshake: a new operand set is accepted every cycle, giving a throughput of 1 result per clock.
REQ-018 Wrap-around: when A + B + cin is 2^32 or greater, sum SHALL be the low 32 bits and cout SHALL be 1.
REQ-019 The addition SHALL be unsigned, with no overflow flag and no saturation.
REQ-020 The combinational critical path SHALL settle within one clock period; it SHALL have at most two lookahead levels plus the sum XOR.
REQ-021 Changes on A, B or cin between clock edges SHALL have no effect on the outputs until the next rising edge.

Reset
REQ-022 When rst is high at a rising clk edge, the next outputs SHALL be cout=0 and sum=32'h00000000, regardless of A, B and cin.
REQ-023 Reset SHALL take priority over a load in the same cycle.
REQ-024 On the first edge after rst falls, the register SHALL load the current A + B + cin.
REQ-025 Before the first clock edge the output state is undefined.
REQ-026 Asserting rst mid-stream SHALL discard the pending result; there is no other internal state.

Verification
REQ-027 A bench SHALL compare {cout,sum} against a behavioural reference of A+B+cin delayed by one clock, on every cycle.
REQ-028 The bench SHALL cover these directed scenarios:
- A=32'h00000000, B=32'h11111111, cin=0, then one edge -> sum=32'h11111111, cout=0.
- A=32'h10101010, B=32'h10101100, cin=0, then one edge -> sum=32'h20202110, cout=0.
- A=32'hFFFFFFFF, B=32'h00000001, cin=0 -> sum=32'h00000000, cout=1; with cin=1 -> sum=32'h00000001, cout=1.
- A=32'hFFFFFFFF, B=32'hFFFFFFFF, cin=1 -> sum=32'hFFFFFFFF, cout=1.
- Carry-chain test: A=32'h0000000F, B=32'h00000001 -> sum=32'h00000010 (carry crosses a block boundary); A=32'h7FFFFFFF, B=32'h00000001 -> sum=32'h80000000, cout=0.
- Reset: apply A=32'h12345678, B=32'h11111111 with rst=1 for one edge -> sum=0, cout=0; drop rst -> next edge sum=32'h23456789, cout=0.
REQ-029 A randomized run of at least 10,000 cycles with random A, B and cin SHALL report zero mismatches against the reference.
